// File: rtl/precalc_fetch_pkg.sv
// Shared definitions for the PreCalc fetch stage: vertex record layout, bounding-box payload and FSM states.
package precalc_fetch_pkg;

    localparam int unsigned REC_W     = 224;
    localparam int unsigned COORD_W   = 12;
    localparam int unsigned BBOX_W    = 4 * COORD_W;
    localparam int unsigned CNT_W_DEF = 8;

    // Coordinate fields of a triangle record; x1 is the most significant field.
    localparam int unsigned X1_LSB = 204;
    localparam int unsigned X2_LSB = 192;
    localparam int unsigned X3_LSB = 180;
    localparam int unsigned Y1_LSB = 168;
    localparam int unsigned Y2_LSB = 156;
    localparam int unsigned Y3_LSB = 144;

    localparam logic [COORD_W-1:0] CLIP_XMAX_DEF = COORD_W'(2559);
    localparam logic [COORD_W-1:0] CLIP_YMAX_DEF = COORD_W'(1919);

    typedef logic [REC_W-1:0] rec_t;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } bbox_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_FETCH = 3'd2,
        ST_BBOX  = 3'd3,
        ST_TEST  = 3'd4,
        ST_PUSH  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    function automatic logic [COORD_W-1:0] coord(input rec_t rec, input int unsigned lsb);
        return rec[lsb +: COORD_W];
    endfunction

endpackage

// File: rtl/precalc_fetch_min_max3.sv
// Combinational minimum and maximum of three unsigned coordinates.
module min_max3
    import precalc_fetch_pkg::*;
(
    input  logic [COORD_W-1:0] a_i,
    input  logic [COORD_W-1:0] b_i,
    input  logic [COORD_W-1:0] c_i,
    output logic [COORD_W-1:0] min_c_o,
    output logic [COORD_W-1:0] max_c_o
);

    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;

    always_comb begin
        lo = a_i;
        hi = a_i;
        if (b_i < lo) lo = b_i;
        if (c_i < lo) lo = c_i;
        if (b_i > hi) hi = b_i;
        if (c_i > hi) hi = c_i;
    end

    assign min_c_o = lo;
    assign max_c_o = hi;

endmodule

// File: rtl/precalc_fetch.sv
// Fetches triangle records from the vertex buffer, computes their screen bounding box,
// culls off-screen / zero-area triangles and pushes survivors into the PreCalc triangle FIFO.
module precalc_fetch
    import precalc_fetch_pkg::*;
#(
    parameter logic [COORD_W-1:0] CLIP_XMAX = CLIP_XMAX_DEF,
    parameter logic [COORD_W-1:0] CLIP_YMAX = CLIP_YMAX_DEF,
    parameter int unsigned        CNT_W     = CNT_W_DEF
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              nextFrame,
    output logic              VertexBuffer_PreCalc_pop,
    input  logic              VertexBuffer_PreCalc_empty,
    input  logic [REC_W-1:0]  VertexBuffer_PreCalc_ReadData,
    output logic [REC_W-1:0]  PreCalc_TriangleFIFO_WriteData,
    output logic [BBOX_W-1:0] PreCalc_BBox,
    output logic              PreCalc_TriangleFIFO_push,
    input  logic              PreCalc_TriangleFIFO_wait,
    output logic [CNT_W-1:0]  tri_count,
    output logic [CNT_W-1:0]  cull_count
);

    state_e           state_q;
    rec_t             rec_q;
    bbox_t            bbox_q;
    bbox_t            bbox_d;
    bbox_t            bbox_out_q;
    rec_t             wdata_q;
    logic             pop_q;
    logic             push_q;
    logic [CNT_W-1:0] tri_q;
    logic [CNT_W-1:0] cull_q;
    logic [CNT_W-1:0] tri_d;
    logic [CNT_W-1:0] cull_d;
    logic             cull_c;

    min_max3 u_mm_x (
        .a_i     (coord(rec_q, X1_LSB)),
        .b_i     (coord(rec_q, X2_LSB)),
        .c_i     (coord(rec_q, X3_LSB)),
        .min_c_o (bbox_d.xmin),
        .max_c_o (bbox_d.xmax)
    );

    min_max3 u_mm_y (
        .a_i     (coord(rec_q, Y1_LSB)),
        .b_i     (coord(rec_q, Y2_LSB)),
        .c_i     (coord(rec_q, Y3_LSB)),
        .min_c_o (bbox_d.ymin),
        .max_c_o (bbox_d.ymax)
    );

    assign cull_c = (bbox_q.xmin > CLIP_XMAX) || (bbox_q.ymin > CLIP_YMAX) ||
                    (bbox_q.xmin == bbox_q.xmax) || (bbox_q.ymin == bbox_q.ymax);

    // Saturating counters: hold at all-ones rather than wrapping.
    assign tri_d  = (tri_q  == '1) ? tri_q  : tri_q  + CNT_W'(1);
    assign cull_d = (cull_q == '1) ? cull_q : cull_q + CNT_W'(1);

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rec_q      <= '0;
            bbox_q     <= '0;
            bbox_out_q <= '0;
            wdata_q    <= '0;
            pop_q      <= 1'b0;
            push_q     <= 1'b0;
            tri_q      <= '0;
            cull_q     <= '0;
        end else begin
            pop_q  <= 1'b0;
            push_q <= 1'b0;
            if (nextFrame) begin
                state_q <= ST_SYNC;
                rec_q   <= '0;
                tri_q   <= '0;
                cull_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_IDLE;
                    // Dead cycle lets the source's lagging empty settle after rewind.
                    ST_SYNC: state_q <= ST_FETCH;
                    ST_FETCH: begin
                        if (VertexBuffer_PreCalc_empty) begin
                            state_q <= ST_DONE;
                        end else begin
                            pop_q   <= 1'b1;
                            rec_q   <= VertexBuffer_PreCalc_ReadData;
                            state_q <= ST_BBOX;
                        end
                    end
                    ST_BBOX: begin
                        bbox_q  <= bbox_d;
                        state_q <= ST_TEST;
                    end
                    ST_TEST: begin
                        if (cull_c) begin
                            cull_q  <= cull_d;
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_PUSH;
                        end
                    end
                    ST_PUSH: begin
                        if (!PreCalc_TriangleFIFO_wait) begin
                            push_q     <= 1'b1;
                            wdata_q    <= rec_q;
                            bbox_out_q <= bbox_q;
                            tri_q      <= tri_d;
                            state_q    <= ST_FETCH;
                        end
                    end
                    ST_DONE: state_q <= ST_DONE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign VertexBuffer_PreCalc_pop       = pop_q;
    assign PreCalc_TriangleFIFO_push      = push_q;
    assign PreCalc_TriangleFIFO_WriteData = wdata_q;
    assign PreCalc_BBox                   = bbox_out_q;
    assign tri_count                      = tri_q;
    assign cull_count                     = cull_q;

endmodule

// File: tb/tb_precalc_fetch.sv
// Scoreboard bench for precalc_fetch: source model, reference cull/bbox model, decoupled push monitor.
module tb_precalc_fetch;

    localparam int MAXR = 300;

    logic         clk100;
    logic         reset;
    logic         nextFrame;
    logic         pop;
    logic         empty;
    logic [223:0] rdata;
    logic [223:0] wdata;
    logic [47:0]  bbox;
    logic         push;
    logic         fifo_wait;
    logic [7:0]   tri_count;
    logic [7:0]   cull_count;

    logic         wait_force;
    logic         wait_rand;
    logic         rand_en;

    precalc_fetch dut (
        .clk100                         (clk100),
        .reset                          (reset),
        .nextFrame                      (nextFrame),
        .VertexBuffer_PreCalc_pop       (pop),
        .VertexBuffer_PreCalc_empty     (empty),
        .VertexBuffer_PreCalc_ReadData  (rdata),
        .PreCalc_TriangleFIFO_WriteData (wdata),
        .PreCalc_BBox                   (bbox),
        .PreCalc_TriangleFIFO_push      (push),
        .PreCalc_TriangleFIFO_wait      (fifo_wait),
        .tri_count                      (tri_count),
        .cull_count                     (cull_count)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    assign fifo_wait = rand_en ? wait_rand : wait_force;

    initial begin
        wait_rand = 1'b0;
        forever begin
            @(negedge clk100);
            wait_rand = ($urandom_range(0, 2) == 0);
        end
    end

    // Vertex buffer model: show-ahead data, empty registered from the index (one cycle lag).
    logic [223:0] recs [0:MAXR-1];
    int           n_recs;
    int           idx;

    initial begin
        idx    = 0;
        empty  = 1'b1;
        n_recs = 0;
    end

    always @(posedge clk100) begin
        if (nextFrame)  idx <= 0;
        else if (pop)   idx <= idx + 1;
        empty <= (idx >= n_recs);
    end

    assign rdata = (idx < n_recs && idx < MAXR) ? recs[idx] : '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [223:0] rec;
        logic [47:0]  bb;
    } exp_t;

    exp_t         exp_q[$];
    int           exp_tri, exp_cull, exp_pushes;
    int           total_pops   = 0;
    int           total_pushes = 0;
    int           base_pops, base_pushes;
    int           cyc          = 0;
    int           last_push    = -100;
    logic [47:0]  push_bb_log[$];

    function automatic int fld(input logic [223:0] r, input int lsb);
        logic [223:0] t;
        t = r >> lsb;
        return int'(t[11:0]);
    endfunction

    // Reference model: screen-space bounds of three points, then the cull rules.
    task automatic load_expect(input int n);
        int   surv = 0;
        int   cul  = 0;
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int xs[3], ys[3];
            int xmin, xmax, ymin, ymax;
            for (int k = 0; k < 3; k++) begin
                xs[k] = fld(recs[i], 204 - 12 * k);
                ys[k] = fld(recs[i], 168 - 12 * k);
            end
            xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
            for (int k = 1; k < 3; k++) begin
                if (xs[k] < xmin) xmin = xs[k];
                if (xs[k] > xmax) xmax = xs[k];
                if (ys[k] < ymin) ymin = ys[k];
                if (ys[k] > ymax) ymax = ys[k];
            end
            if (xmin > 2559 || ymin > 1919 || xmin == xmax || ymin == ymax) begin
                cul++;
            end else begin
                e.rec = recs[i];
                e.bb  = {12'(xmin), 12'(xmax), 12'(ymin), 12'(ymax)};
                exp_q.push_back(e);
                surv++;
            end
        end
        exp_pushes = surv;
        exp_tri    = (surv > 255) ? 255 : surv;
        exp_cull   = (cul  > 255) ? 255 : cul;
    endtask

    // Monitor: counts pops, checks every push against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk100);
            #1;
            cyc++;
            if (pop) total_pops++;
            if (push) begin
                check("push spacing>=4", 224'(cyc - last_push >= 4), 224'(1));
                last_push = cyc;
                total_pushes++;
                push_bb_log.push_back(bbox);
                if (exp_q.size() == 0) begin
                    check("unexpected push", 224'(1), 224'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("WriteData", wdata, e.rec);
                    check("BBox", 224'(bbox), 224'(e.bb));
                end
            end
        end
    end

    function automatic logic [223:0] make_rec(input int x1, x2, x3, y1, y2, y3);
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r[215:204] = 12'(x1);
        r[203:192] = 12'(x2);
        r[191:180] = 12'(x3);
        r[179:168] = 12'(y1);
        r[167:156] = 12'(y2);
        r[155:144] = 12'(y3);
        return r;
    endfunction

    function automatic int rnd_c(input int lim);
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(lim + 1, 4095));
        return int'($urandom_range(0, lim));
    endfunction

    function automatic logic [223:0] rand_rec();
        int  x1, y1;
        bit  dx, dy;
        x1 = rnd_c(2559);
        y1 = rnd_c(1919);
        dx = ($urandom_range(0, 7) == 0);
        dy = ($urandom_range(0, 7) == 0);
        return make_rec(x1, dx ? x1 : rnd_c(2559), dx ? x1 : rnd_c(2559),
                        y1, dy ? y1 : rnd_c(1919), dy ? y1 : rnd_c(1919));
    endfunction

    task automatic start_frame(input int n);
        n_recs = n;
        load_expect(n);
        base_pops   = total_pops;
        base_pushes = total_pushes;
        @(negedge clk100);
        nextFrame = 1'b1;
        @(negedge clk100);
        nextFrame = 1'b0;
    endtask

    task automatic finish_frame(input int n, input string name);
        bit done = 1'b0;
        for (int c = 0; c < 12 * n + 300; c++) begin
            @(negedge clk100);
            if (total_pops - base_pops >= n && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check({name, " completes"}, 224'(done), 224'(1));
        repeat (8) @(negedge clk100);
        check({name, " pops"}, 224'(total_pops - base_pops), 224'(n));
        check({name, " pushes"}, 224'(total_pushes - base_pushes), 224'(exp_pushes));
        check({name, " tri_count"}, 224'(tri_count), 224'(exp_tri));
        check({name, " cull_count"}, 224'(cull_count), 224'(exp_cull));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        nextFrame  = 1'b0;
        wait_force = 1'b0;
        rand_en    = 1'b0;
        #23;
        check("reset pop", 224'(pop), 224'(0));
        check("reset push", 224'(push), 224'(0));
        check("reset WriteData", wdata, 224'(0));
        check("reset BBox", 224'(bbox), 224'(0));
        check("reset tri_count", 224'(tri_count), 224'(0));
        check("reset cull_count", 224'(cull_count), 224'(0));
        @(negedge clk100);
        reset = 1'b0;
        repeat (6) @(negedge clk100);
        check("idle no pop", 224'(total_pops), 224'(0));

        // Three on-screen triangles.
        recs[0] = make_rec(100, 300, 200, 50, 50, 400);
        recs[1] = make_rec(10, 20, 30, 40, 50, 60);
        recs[2] = make_rec(2000, 2500, 1500, 1000, 1900, 1200);
        start_frame(3);
        finish_frame(3, "frameA");
        if (push_bb_log.size() > base_pushes)
            check("frameA first BBox", 224'(push_bb_log[base_pushes]),
                  224'({12'd100, 12'd300, 12'd50, 12'd400}));
        else
            check("frameA first BBox present", 224'(0), 224'(1));

        // Off-screen and zero-area culls.
        recs[0] = make_rec(2600, 2700, 2650, 5, 100, 50);
        recs[1] = make_rec(10, 20, 30, 10, 10, 10);
        start_frame(2);
        finish_frame(2, "frameB");

        // Clip-edge boundaries.
        recs[0] = make_rec(2559, 2600, 2700, 0, 1919, 5);
        recs[1] = make_rec(1, 2, 3, 1920, 1930, 1925);
        recs[2] = make_rec(7, 7, 7, 3, 9, 20);
        recs[3] = make_rec(0, 5, 9, 1919, 1919, 1920);
        start_frame(4);
        finish_frame(4, "frameC");

        // Back-pressure held for 20+ cycles in PUSH.
        wait_force = 1'b1;
        recs[0] = make_rec(400, 800, 600, 300, 900, 100);
        start_frame(1);
        repeat (26) @(negedge clk100);
        check("wait holds push", 224'(total_pushes - base_pushes), 224'(0));
        wait_force = 1'b0;
        @(posedge clk100);
        #1;
        check("push after wait falls", 224'(push), 224'(1));
        @(posedge clk100);
        #1;
        check("no duplicate push", 224'(push), 224'(0));
        finish_frame(1, "frameW");

        // nextFrame while the second record sits in BBOX.
        recs[0] = make_rec(100, 200, 150, 100, 200, 300);
        recs[1] = make_rec(500, 600, 700, 500, 520, 510);
        start_frame(2);
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk100);
                if (total_pops - base_pops == 2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("restart reached 2nd pop", 224'(seen), 224'(1));
        end
        check("restart pushes before", 224'(total_pushes - base_pushes), 224'(1));
        load_expect(2);
        base_pops   = total_pops;
        base_pushes = total_pushes;
        nextFrame   = 1'b1;
        @(posedge clk100);
        #1;
        check("restart tri cleared", 224'(tri_count), 224'(0));
        check("restart pop low E0", 224'(pop), 224'(0));
        @(negedge clk100);
        nextFrame = 1'b0;
        @(posedge clk100);
        #1;
        check("restart pop low E1", 224'(pop), 224'(0));
        @(posedge clk100);
        #1;
        check("restart pop at E2", 224'(pop), 224'(1));
        finish_frame(2, "frameR");

        // Asynchronous reset while stalled in PUSH.
        wait_force = 1'b1;
        recs[0] = make_rec(50, 60, 70, 50, 80, 90);
        start_frame(1);
        repeat (12) @(negedge clk100);
        #2;
        reset = 1'b1;
        #1;
        check("async reset push", 224'(push), 224'(0));
        check("async reset pop", 224'(pop), 224'(0));
        check("async reset tri", 224'(tri_count), 224'(0));
        check("async reset WriteData", wdata, 224'(0));
        exp_q.delete();
        @(negedge clk100);
        reset       = 1'b0;
        wait_force  = 1'b0;
        base_pops   = total_pops;
        base_pushes = total_pushes;
        repeat (20) @(negedge clk100);
        check("post-reset no pop", 224'(total_pops - base_pops), 224'(0));
        check("post-reset no push", 224'(total_pushes - base_pushes), 224'(0));

        // Randomized frames with random back-pressure.
        rand_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int n;
            n = int'($urandom_range(5, 40));
            for (int i = 0; i < n; i++) recs[i] = rand_rec();
            start_frame(n);
            finish_frame(n, "random");
        end
        rand_en = 1'b0;

        // Cull counter saturation.
        for (int i = 0; i < 262; i++) recs[i] = make_rec(3000, 3100, 3050, 10, 20, 30);
        start_frame(262);
        finish_frame(262, "saturate");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
